// File: rtl/easyaxi_top.sv
// AXI4 demo: an internal master writes BURST_NUM INCR bursts into an internal slave memory, then raises done.
// Define EASYAXI_READBACK_EN to add the read-back phase with data checking (sticky err).
module easyaxi_top #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int BURST_NUM = 4
) (
    input  logic clk,
    input  logic rst_n,   // synchronous, active-high despite the name
    input  logic enable,
    output logic done
);
    localparam int BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int BURST_W = (BURST_NUM > 1) ? $clog2(BURST_NUM) : 1;
    localparam int DEPTH   = 2 ** (ADDR_W - 2);
    localparam int STRB_W  = DATA_W / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_WORD   = 3'd2;

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} m_state_t;
    typedef enum logic [1:0] {S_IDLE, S_WR, S_RESP, S_RD} s_state_t;

    // Every channel: a transfer happens on a rising edge with VALID and READY both 1;
    // once VALID is raised it and its payload hold steady until that transfer.
    logic              aw_valid, aw_ready;
    logic [ADDR_W-1:0] aw_addr;
    logic [7:0]        aw_len;
    logic [2:0]        aw_size;
    logic [1:0]        aw_burst;
    logic              w_valid, w_ready, w_last;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              b_valid, b_ready;
    logic [1:0]        b_resp;

    m_state_t           state, state_nxt;
    s_state_t           s_state, s_state_nxt;
    logic [BURST_W-1:0] burst_cnt;
    logic [BEAT_W-1:0]  beat_cnt;
    logic               req_active, ar_wait, m_ready, err;
    logic               last_burst, beat_last, rd_beat, rd_last;
    logic [DATA_W-1:0]  beat_pattern;
    logic [ADDR_W-1:0]  burst_addr;

    logic [ADDR_W-1:0] s_addr, s_addr_nxt;
    logic [7:0]        s_len, s_cnt;
    logic [2:0]        s_size;
    logic [1:0]        s_burst;
    logic              s_werr;
    logic [DATA_W-1:0] mem [DEPTH];

    assign last_burst   = (burst_cnt == BURST_W'(BURST_NUM - 1));
    assign beat_last    = (beat_cnt == BEAT_W'(BURST_LEN - 1));
    assign burst_addr   = ADDR_W'(int'(burst_cnt) * BURST_LEN * 4);
    assign beat_pattern = DATA_W'(32'hDA7A_0000 | (32'(burst_cnt) << 8) | 32'(beat_cnt));

    // Master issue: enable gates only the first cycle of VALID; req_active keeps it up until accepted.
    assign aw_valid = (state == WR_ADDR) && (enable || req_active);
    assign aw_addr  = burst_addr;
    assign aw_len   = 8'(BURST_LEN - 1);
    assign aw_size  = SIZE_WORD;
    assign aw_burst = BURST_INCR;
    assign w_valid  = (state == WR_DATA);
    assign w_data   = beat_pattern;
    assign w_strb   = '1;
    assign w_last   = beat_last;
    assign b_ready  = m_ready;
    assign done     = (state == DONE);

    assign w_ready    = (s_state == S_WR);
    assign b_valid    = (s_state == S_RESP);
    assign b_resp     = s_werr ? RESP_SLVERR : RESP_OKAY;
    assign s_addr_nxt = (s_burst == BURST_INCR) ? s_addr + (ADDR_W'(1) << s_size) : s_addr;

`ifdef EASYAXI_READBACK_EN
    localparam m_state_t WR_NEXT = RD_ADDR;
    logic              ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [ADDR_W-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst, r_resp;
    logic [DATA_W-1:0] r_data;

    assign ar_valid = (state == RD_ADDR) && (enable || req_active);
    assign ar_addr  = burst_addr;
    assign ar_len   = 8'(BURST_LEN - 1);
    assign ar_size  = SIZE_WORD;
    assign ar_burst = BURST_INCR;
    assign r_ready  = m_ready;
    assign r_valid  = (s_state == S_RD);
    assign r_data   = mem[s_addr[ADDR_W-1:2]];
    assign r_resp   = RESP_OKAY;
    assign r_last   = (s_cnt == s_len);
    assign ar_wait  = ar_valid && !ar_ready;
    assign rd_beat  = r_valid && r_ready;
    assign rd_last  = r_last;

    always_ff @(posedge clk) begin
        if (rst_n)
            err <= 1'b0;
        else if ((rd_beat && (r_data != beat_pattern || r_resp != RESP_OKAY || r_last != beat_last)) ||
                 (b_valid && b_ready && b_resp != RESP_OKAY))
            err <= 1'b1;
    end
`else
    localparam m_state_t WR_NEXT = DONE;
    assign ar_wait = 1'b0;
    assign rd_beat = 1'b0;
    assign rd_last = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = WR_ADDR;
            WR_ADDR: if (aw_valid && aw_ready) state_nxt = WR_DATA;
            WR_DATA: if (w_valid && w_ready && w_last) state_nxt = WR_RESP;
            WR_RESP: if (b_valid && b_ready) state_nxt = last_burst ? WR_NEXT : WR_ADDR;
`ifdef EASYAXI_READBACK_EN
            RD_ADDR: if (ar_valid && ar_ready) state_nxt = RD_DATA;
            RD_DATA: if (rd_beat && rd_last) state_nxt = last_burst ? DONE : RD_ADDR;
`endif
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            beat_cnt   <= '0;
            req_active <= 1'b0;
            m_ready    <= 1'b0;
        end else begin
            state      <= state_nxt;
            m_ready    <= 1'b1;
            req_active <= (aw_valid && !aw_ready) || ar_wait;
            if ((w_valid && w_ready) || rd_beat)
                beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
            if ((b_valid && b_ready) || (rd_beat && rd_last))
                burst_cnt <= last_burst ? '0 : burst_cnt + 1'b1;
        end
    end

    always_comb begin
        s_state_nxt = s_state;
        case (s_state)
            S_IDLE: begin
                if (aw_valid && aw_ready) s_state_nxt = S_WR;
`ifdef EASYAXI_READBACK_EN
                else if (ar_valid && ar_ready) s_state_nxt = S_RD;
`endif
            end
            S_WR:   if (w_valid && w_ready && w_last) s_state_nxt = S_RESP;
            S_RESP: if (b_valid && b_ready) s_state_nxt = S_IDLE;
`ifdef EASYAXI_READBACK_EN
            S_RD:   if (rd_beat && r_last) s_state_nxt = S_IDLE;
`endif
            default: s_state_nxt = S_IDLE;
        endcase
    end

    // Slave: a WLAST that disagrees with the accepted AWLEN turns the B response into SLVERR.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            s_state  <= S_IDLE;
            aw_ready <= 1'b0;
            s_addr   <= '0;
            s_len    <= '0;
            s_cnt    <= '0;
            s_size   <= '0;
            s_burst  <= '0;
            s_werr   <= 1'b0;
`ifdef EASYAXI_READBACK_EN
            ar_ready <= 1'b0;
`endif
        end else begin
            s_state  <= s_state_nxt;
            aw_ready <= (s_state == S_IDLE) && aw_valid && !aw_ready;
`ifdef EASYAXI_READBACK_EN
            ar_ready <= (s_state == S_IDLE) && ar_valid && !ar_ready && !aw_valid;
`endif
            if (aw_valid && aw_ready) begin
                s_addr  <= aw_addr;
                s_len   <= aw_len;
                s_size  <= aw_size;
                s_burst <= aw_burst;
                s_cnt   <= '0;
                s_werr  <= 1'b0;
`ifdef EASYAXI_READBACK_EN
            end else if (ar_valid && ar_ready) begin
                s_addr  <= ar_addr;
                s_len   <= ar_len;
                s_size  <= ar_size;
                s_burst <= ar_burst;
                s_cnt   <= '0;
`endif
            end else if ((w_valid && w_ready) || rd_beat) begin
                s_addr <= s_addr_nxt;
                s_cnt  <= s_cnt + 1'b1;
            end
            if (w_valid && w_ready && (w_last != (s_cnt == s_len)))
                s_werr <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_valid && w_ready)
            for (int b = 0; b < STRB_W; b++)
                if (w_strb[b]) mem[s_addr[ADDR_W-1:2]][b*8 +: 8] <= w_data[b*8 +: 8];
    end

endmodule

// File: tb/tb_easyaxi_top.sv
// Directed bench for easyaxi_top: write/read-back sequence, enable gating, sticky done and mid-run reset.
module tb_easyaxi_top;
  localparam int BURST_LEN = 4;
  localparam int BURST_NUM = 4;
  localparam int BEATS     = BURST_LEN * BURST_NUM;

  logic clk;
  logic rst_n;
  logic enable;
  logic done;
  int checks = 0;
  int errors = 0;

  easyaxi_top #(.DATA_W(32), .ADDR_W(8), .BURST_LEN(BURST_LEN), .BURST_NUM(BURST_NUM)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor: samples on the falling edge, records transfers with cycle stamps.
  int cyc = 0;
  logic done_d = 1'b0;
  int done_rise_cyc = -1;
  int aw_valid_cyc = 0;
  int rd_phase_cyc = 0;
  int overlap_cyc = 0;
  logic [7:0]  obs_aw_q[$];
  logic [32:0] obs_w_q[$];
  logic [1:0]  obs_b_q[$];
  int          obs_b_cyc_q[$];
  logic [7:0]  obs_ar_q[$];
  logic [32:0] obs_r_q[$];
  int          obs_r_cyc_q[$];
  logic [32:0] exp_q[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (dut.aw_valid === 1'b1) aw_valid_cyc = aw_valid_cyc + 1;
    if (dut.aw_valid === 1'b1 && dut.w_valid === 1'b1) overlap_cyc = overlap_cyc + 1;
    if (dut.state == 3'd4 || dut.state == 3'd5) rd_phase_cyc = rd_phase_cyc + 1;
    if (dut.aw_valid && dut.aw_ready) obs_aw_q.push_back(dut.aw_addr);
    if (dut.w_valid && dut.w_ready) obs_w_q.push_back({dut.w_last, dut.w_data});
    if (dut.b_valid && dut.b_ready) begin
      obs_b_q.push_back(dut.b_resp);
      obs_b_cyc_q.push_back(cyc);
    end
`ifdef EASYAXI_READBACK_EN
    if (dut.ar_valid && dut.ar_ready) obs_ar_q.push_back(dut.ar_addr);
    if (dut.r_valid && dut.r_ready) begin
      obs_r_q.push_back({dut.r_last, dut.r_data});
      obs_r_cyc_q.push_back(cyc);
    end
`endif
    if (done === 1'b1 && done_d !== 1'b1) done_rise_cyc = cyc;
    done_d = done;
  end

  function automatic logic [31:0] pattern(int k, int j);
    return 32'hDA7A_0000 | (32'(k) << 8) | 32'(j);
  endfunction

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    enable = 1'b0;
    rst_n  = 1'b1;
    step();
    rst_n  = 1'b0;
  endtask

  task automatic test_reset;
    enable = 1'b0;
    rst_n  = 1'b1;
    step();
    checks++;
    if ({done, dut.aw_valid, dut.aw_ready, dut.w_valid, dut.w_ready, dut.b_valid, dut.b_ready} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 0000000", {done, dut.aw_valid, dut.aw_ready, dut.w_valid, dut.w_ready, dut.b_valid, dut.b_ready});
    end
    checks++;
    if (dut.state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", dut.state); end
    checks++;
    if (dut.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", dut.err); end
`ifdef EASYAXI_READBACK_EN
    checks++;
    if ({dut.ar_valid, dut.ar_ready, dut.r_valid, dut.r_ready} !== 4'b0) begin
      errors++;
      $display("FAIL reset_rd: got %b, required 0000", {dut.ar_valid, dut.ar_ready, dut.r_valid, dut.r_ready});
    end
`endif
    rst_n = 1'b0;
  endtask

  task automatic test_idle_disabled;
    int base;
    base = aw_valid_cyc;
    enable = 1'b0;
    repeat (100) step();
    checks++;
    if (aw_valid_cyc - base !== 0) begin errors++; $display("FAIL idle_awvalid: got %0d cycles, required 0", aw_valid_cyc - base); end
    checks++;
    if (done !== 1'b0 || dut.state !== 3'd0) begin
      errors++;
      $display("FAIL idle_done: got done=%b state=%0d, required done=0 state=0", done, dut.state);
    end
  endtask

  task automatic test_full_run;
    int aw_b, w_b, b_b, ar_b, r_b;
    bit got;
    logic [32:0] exp_v, got_v;
    logic [7:0] got_a;
    do_reset();
    repeat (5) step();
    aw_b = obs_aw_q.size(); w_b = obs_w_q.size(); b_b = obs_b_q.size();
    ar_b = obs_ar_q.size(); r_b = obs_r_q.size();
    enable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      step();
      if (done === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL run_done: got done=%b after 80 cycles, required 1", done); end

    for (int k = 0; k < BURST_NUM; k++) begin
      got_a = (aw_b + k < obs_aw_q.size()) ? obs_aw_q[aw_b + k] : 8'hxx;
      checks++;
      if (got_a !== 8'(k * 16)) begin errors++; $display("FAIL awaddr[%0d]: got %h, required %h", k, got_a, 8'(k * 16)); end
    end

    exp_q.delete();
    for (int k = 0; k < BURST_NUM; k++)
      for (int j = 0; j < BURST_LEN; j++)
        exp_q.push_back({(j == BURST_LEN - 1), pattern(k, j)});
    for (int i = 0; i < BEATS; i++) begin
      exp_v = exp_q.pop_front();
      got_v = (w_b + i < obs_w_q.size()) ? obs_w_q[w_b + i] : 33'hx;
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL wbeat[%0d]: got %h, required %h", i, got_v, exp_v); end
    end

    checks++;
    if (obs_b_q.size() - b_b !== BURST_NUM) begin
      errors++;
      $display("FAIL bcount: got %0d, required %0d", obs_b_q.size() - b_b, BURST_NUM);
    end
    for (int k = b_b; k < obs_b_q.size(); k++) begin
      checks++;
      if (obs_b_q[k] !== 2'b00) begin errors++; $display("FAIL bresp[%0d]: got %b, required 00", k - b_b, obs_b_q[k]); end
    end
    checks++;
    if (overlap_cyc !== 0) begin errors++; $display("FAIL aw_w_overlap: got %0d cycles, required 0", overlap_cyc); end

`ifdef EASYAXI_READBACK_EN
    for (int k = 0; k < BURST_NUM; k++) begin
      got_a = (ar_b + k < obs_ar_q.size()) ? obs_ar_q[ar_b + k] : 8'hxx;
      checks++;
      if (got_a !== 8'(k * 16)) begin errors++; $display("FAIL araddr[%0d]: got %h, required %h", k, got_a, 8'(k * 16)); end
    end
    exp_q.delete();
    for (int k = 0; k < BURST_NUM; k++)
      for (int j = 0; j < BURST_LEN; j++)
        exp_q.push_back({(j == BURST_LEN - 1), pattern(k, j)});
    for (int i = 0; i < BEATS; i++) begin
      exp_v = exp_q.pop_front();
      got_v = (r_b + i < obs_r_q.size()) ? obs_r_q[r_b + i] : 33'hx;
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL rbeat[%0d]: got %h, required %h", i, got_v, exp_v); end
    end
    got_v = (r_b + 6 < obs_r_q.size()) ? obs_r_q[r_b + 6] : 33'hx;
    checks++;
    if (got_v !== 33'h0_DA7A_0102) begin errors++; $display("FAIL r_b1_beat2: got %h, required 0da7a0102", got_v); end
    got_v = (r_b + 7 < obs_r_q.size()) ? obs_r_q[r_b + 7] : 33'hx;
    checks++;
    if (got_v !== 33'h1_DA7A_0103) begin errors++; $display("FAIL r_b1_beat3: got %h, required 1da7a0103", got_v); end
    checks++;
    if (obs_r_cyc_q.size() == 0 || done_rise_cyc !== obs_r_cyc_q[$] + 1) begin
      errors++;
      $display("FAIL done_after_last_r: got cycle %0d, required one after last R beat", done_rise_cyc);
    end
`else
    checks++;
    if (rd_phase_cyc !== 0) begin errors++; $display("FAIL no_read_phase: got %0d read cycles, required 0", rd_phase_cyc); end
    checks++;
    if (obs_b_cyc_q.size() == 0 || done_rise_cyc !== obs_b_cyc_q[$] + 1) begin
      errors++;
      $display("FAIL done_after_last_b: got cycle %0d, required one after 4th B", done_rise_cyc);
    end
`endif
    checks++;
    if (dut.err !== 1'b0) begin errors++; $display("FAIL run_err: got %b, required 0", dut.err); end
  endtask

  task automatic test_enable_drop;
    int aw_b, b_b, base;
    bit got;
    do_reset();
    aw_b = obs_aw_q.size(); b_b = obs_b_q.size();
    enable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (obs_aw_q.size() >= aw_b + 2) got = 1'b1;
    end
    enable = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL drop_aw1: got %0d AW, required 2", obs_aw_q.size() - aw_b); end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (obs_b_q.size() >= b_b + 2) got = 1'b1;
    end
    checks++;
    if (!got || obs_b_q[b_b + 1] !== 2'b00) begin
      errors++;
      $display("FAIL drop_b1: got %0d B handshakes, required burst 1 OKAY", obs_b_q.size() - b_b);
    end
    base = aw_valid_cyc;
    repeat (20) step();
    checks++;
    if (aw_valid_cyc - base !== 0 || dut.state !== 3'd1) begin
      errors++;
      $display("FAIL drop_hold: got awvalid cycles=%0d state=%0d, required 0 and 1", aw_valid_cyc - base, dut.state);
    end
    enable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      step();
      if (done === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || obs_aw_q.size() - aw_b !== BURST_NUM) begin
      errors++;
      $display("FAIL drop_resume: got done=%b aw=%0d, required done=1 aw=%0d", done, obs_aw_q.size() - aw_b, BURST_NUM);
    end
  endtask

  task automatic test_done_sticky;
    int low_cyc;
    low_cyc = 0;
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done !== 1'b1) low_cyc++;
    end
    checks++;
    if (low_cyc !== 0 || dut.state !== 3'd6) begin
      errors++;
      $display("FAIL done_sticky: got %0d low cycles state=%0d, required 0 and 6", low_cyc, dut.state);
    end
  endtask

  task automatic test_reset_mid_run;
    int aw_b, mark;
    bit got;
    do_reset();
    enable = 1'b1;
`ifdef EASYAXI_READBACK_EN
    mark = obs_ar_q.size();
`else
    mark = obs_b_q.size();
`endif
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      step();
`ifdef EASYAXI_READBACK_EN
      if (obs_ar_q.size() > mark) got = 1'b1;
`else
      if (obs_b_q.size() >= mark + 3) got = 1'b1;
`endif
    end
    checks++;
    if (!got) begin errors++; $display("FAIL mid_reach: got %b, required 1", got); end
    rst_n = 1'b1;
    step();
    checks++;
    if (done !== 1'b0 || dut.state !== 3'd0 || dut.w_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got done=%b state=%0d wvalid=%b, required 0 0 0", done, dut.state, dut.w_valid);
    end
    rst_n = 1'b0;
    aw_b = obs_aw_q.size();
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      step();
      if (done === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || dut.err !== 1'b0 || obs_aw_q.size() - aw_b !== BURST_NUM || obs_aw_q[aw_b] !== 8'h00) begin
      errors++;
      $display("FAIL rerun: got done=%b err=%b aw=%0d, required 1 0 %0d from 00", done, dut.err, obs_aw_q.size() - aw_b, BURST_NUM);
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    enable = 1'b0;
    test_reset();
    test_idle_disabled();
    test_full_run();
    test_enable_drop();
    test_done_sticky();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
